rst_seq_ctrl: RTL
=================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2: synchroniser flop depth per request input (>=2).
REQ-002 SHALL have parameter NUM_SRC, default 4: number of external reset-request inputs (>=1).
REQ-003 SHALL have parameter NUM_OUT, default 3: number of sequenced reset outputs (>=1).
REQ-004 SHALL have parameter HOLD_CYC, default 8: minimum quiet cycles in ASSERT before release (>=1).
REQ-005 SHALL have parameter STAGGER_CYC, default 4: cycles between consecutive output releases (>=1).
REQ-006 SHALL have port CLK, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port RST, input, 1: global reset, synchronous, active-high.
REQ-008 SHALL have port RST_REQ_N, input, NUM_SRC: asynchronous active-low reset requests.
REQ-009 SHALL have port SW_RST, input, 1: CLK-synchronous active-high software reset request.
REQ-010 SHALL have port CAUSE_CLR, input, 1: synchronous clear of RST_CAUSE.
REQ-011 SHALL have port SYNC_RST, output, NUM_OUT: active-low sequenced resets, bit 0 released first.
REQ-012 SHALL have port RST_ACTIVE, output, 1: high while any SYNC_RST bit is low.
REQ-013 SHALL have port SEQ_DONE, output, 1: high in RUN only.
REQ-014 SHALL have port RST_CAUSE, output, NUM_SRC+1: sticky cause flags; bits NUM_SRC-1..0 = RST_REQ_N sources, bit NUM_SRC = SW_RST.

Function
REQ-015 SHALL pass each RST_REQ_N bit through its own NUM_STAGES-flop chain; only chain outputs are used downstream.
REQ-016 SHALL compute req_any = (any synchronised request bit low) OR SW_RST, combinationally.
REQ-017 SHALL implement FSM states ASSERT, RELEASE, RUN; all registered outputs change only on clock edges.
REQ-018 ASSERT: all SYNC_RST bits 0; hold_cnt cleared on every edge with req_any=1, else incremented; on edge with req_any=0 and hold_cnt==HOLD_CYC-1 -> RELEASE with stag_cnt=0, idx=0.
REQ-019 RELEASE: on edge with stag_cnt==STAGGER_CYC-1 set SYNC_RST[idx]=1, clear stag_cnt, increment idx; else increment stag_cnt.
REQ-020 RELEASE: release of SYNC_RST[NUM_OUT-1] SHALL occur on the same edge as transition to RUN.
REQ-021 RUN: all SYNC_RST bits 1, SEQ_DONE=1, RST_ACTIVE=0; remain until req_any.
REQ-022 Edge with req_any=1 in RELEASE or RUN: next state ASSERT, all SYNC_RST=0, SEQ_DONE=0, RST_ACTIVE=1, all counters 0, same edge.
REQ-023 Release latency SHALL be: SYNC_RST[k] rises on rising edge number NUM_STAGES+HOLD_CYC+STAGGER_CYC*(k+1), counted from the first edge with RST=0 and all RST_REQ_N high.
REQ-024 RST_CAUSE bit SHALL set on any edge its synchronised source (or SW_RST) is active, in any state.
REQ-025 CAUSE_CLR SHALL clear all RST_CAUSE bits; a set on the same edge SHALL win for that bit.
REQ-026 SYNC_RST bits SHALL never rise out of index order and never more than one per edge.

Reset
REQ-027 RST=1 SHALL on the next edge force: state ASSERT, counters 0, all synchroniser flops 0, SYNC_RST all 0, RST_ACTIVE=1, SEQ_DONE=0, RST_CAUSE all 0.
REQ-028 RST=1 mid-RELEASE or RUN SHALL override all other inputs, including CAUSE_CLR.

Verification (defaults)
REQ-029 RST high 3 cycles then low, RST_REQ_N=all 1 -> SYNC_RST[0/1/2] rise on edges 14/18/22, SEQ_DONE=1 and RST_ACTIVE=0 from edge 22.
REQ-030 In RUN, RST_REQ_N[2] low 1 cycle -> SYNC_RST=3'b000 on edge 2 after assertion, RST_CAUSE[2]=1, re-release at 8+4 edges after synchronised request clears.
REQ-031 In RELEASE after SYNC_RST[0] rises, SW_RST pulse -> SYNC_RST=0 next edge, RST_CAUSE[4]=1, full sequence restarts.
REQ-032 In ASSERT, request toggles every 5 cycles -> hold_cnt never reaches 7, SYNC_RST stays 3'b000.
REQ-033 CAUSE_CLR with RST_REQ_N[0] held low -> RST_CAUSE[0] stays 1; other bits clear to 0.
REQ-034 RST asserted at edge 20 of REQ-029 -> all outputs at reset values on edge 21.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises reset requests, holds all outputs low for a quiet period, then
// releases SYNC_RST bits in index order STAGGER_CYC apart; no backpressure, any request re-asserts at once.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_SRC     = 4,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYC    = 8,
    parameter int STAGGER_CYC = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] RST_REQ_N,
    input  logic               SW_RST,
    input  logic               CAUSE_CLR,
    output logic [NUM_OUT-1:0] SYNC_RST,
    output logic               RST_ACTIVE,
    output logic               SEQ_DONE,
    output logic [NUM_SRC:0]   RST_CAUSE
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int STAG_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [STAG_W-1:0]  STAG_LAST = STAG_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] OUT_ONE   = NUM_OUT'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                              state;
    logic [HOLD_W-1:0]                   hold_cnt;
    logic [STAG_W-1:0]                   stag_cnt;
    logic [IDX_W-1:0]                    idx;
    logic [NUM_STAGES-1:0][NUM_SRC-1:0]  sync_ff;
    logic [NUM_SRC-1:0]                  sync_n;
    logic [NUM_SRC:0]                    cause_set;
    logic                                req_any;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[NUM_STAGES-2:0], RST_REQ_N};
        end
    end

    assign sync_n    = sync_ff[NUM_STAGES-1];
    assign req_any   = (~&sync_n) | SW_RST;
    assign cause_set = {SW_RST, ~sync_n};

    // A source still active during a clear keeps its flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RST_CAUSE <= '0;
        end else if (CAUSE_CLR) begin
            RST_CAUSE <= cause_set;
        end else begin
            RST_CAUSE <= RST_CAUSE | cause_set;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || req_any) begin
            state      <= ST_ASSERT;
            hold_cnt   <= '0;
            stag_cnt   <= '0;
            idx        <= '0;
            SYNC_RST   <= '0;
            RST_ACTIVE <= 1'b1;
            SEQ_DONE   <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RELEASE;
                        hold_cnt <= '0;
                        stag_cnt <= '0;
                        idx      <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stag_cnt == STAG_LAST) begin
                        SYNC_RST <= SYNC_RST | (OUT_ONE << idx);
                        stag_cnt <= '0;
                        // Last output leaves reset on the same edge the sequence completes.
                        if (idx == IDX_LAST) begin
                            state      <= ST_RUN;
                            idx        <= '0;
                            RST_ACTIVE <= 1'b0;
                            SEQ_DONE   <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    SYNC_RST   <= '1;
                    RST_ACTIVE <= 1'b0;
                    SEQ_DONE   <= 1'b1;
                end
                default: begin
                    state      <= ST_ASSERT;
                    hold_cnt   <= '0;
                    stag_cnt   <= '0;
                    idx        <= '0;
                    SYNC_RST   <= '0;
                    RST_ACTIVE <= 1'b1;
                    SEQ_DONE   <= 1'b0;
                end
            endcase
        end
    end

endmodule
